nco_sweep_ctrl: RTL and testbench



---
 rtl/nco_sweep_pkg.sv | 7 +
 rtl/nco_sweep_if.sv | 30 +++
 rtl/nco_sweep_phase_step.sv | 17 +
 rtl/nco_sweep_ctrl.sv | 106 ++++++++++
 tb/tb_nco_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared state encoding and default widths for the NCO sweep sequencer
package nco_sweep_pkg;
    localparam int APR_D = 32;
    localparam int NSW_D = 16;
    localparam int DW_D  = 16;
    typedef enum logic [1:0] {IDLE, WARM, SWEEP, DONE} state_t;
endpackage

// File: rtl/nco_sweep_if.sv
// nco_sweep_if: sweep request/config bus plus the NCO-facing controls and status
interface nco_sweep_if
    import nco_sweep_pkg::*;
#(
    parameter int APR = APR_D,
    parameter int NSW = NSW_D,
    parameter int DW  = DW_D
);
    logic           start;
    logic           abort;
    logic [APR-1:0] f_start;
    logic [APR-1:0] f_step;
    logic [NSW-1:0] n_steps;
    logic [DW-1:0]  dwell;
    logic           nco_valid;
    logic [APR-1:0] phi_inc_o;
    logic           nco_clken_o;
    logic           busy;
    logic           step_strobe;
    logic [NSW-1:0] step_idx;
    logic           done;
    modport master (
        output start, abort, f_start, f_step, n_steps, dwell, nco_valid,
        input  phi_inc_o, nco_clken_o, busy, step_strobe, step_idx, done
    );
    modport slave (
        input  start, abort, f_start, f_step, n_steps, dwell, nco_valid,
        output phi_inc_o, nco_clken_o, busy, step_strobe, step_idx, done
    );
endinterface

// File: rtl/nco_sweep_phase_step.sv
// nco_sweep_phase_step: phase-increment register with clear, load and modulo-2^APR step
module nco_sweep_phase_step #(
    parameter int APR = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           ld,
    input  logic           step,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_step,
    output logic [APR-1:0] phi
);
    always_ff @(posedge clk or posedge reset)
        if (reset) phi <= '0;
        else       phi <= clr ? '0 : ld ? f_start : step ? phi + f_step : phi;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: warms up the NCO at f_start, then steps the increment linearly with a fixed dwell
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR = APR_D,
    parameter int NSW = NSW_D,
    parameter int DW  = DW_D
) (
    input  logic      clk,
    input  logic      reset,
    nco_sweep_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WARM  = WARM;
    localparam logic [1:0] ST_SWEEP = SWEEP;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]     state;
    logic [APR-1:0] step_r;
    logic [NSW-1:0] n_r;
    logic [DW-1:0]  dwell_r;
    logic [DW-1:0]  cnt;
    logic           accept;
    logic           last_step;
    logic           ph_step;

    assign accept    = state == ST_IDLE && bus.start && !bus.abort;
    assign last_step = bus.step_idx == n_r - NSW'(1);
    assign ph_step   = state == ST_SWEEP && !bus.abort && cnt == '0 && !last_step;

    nco_sweep_phase_step #(.APR(APR)) u_phase (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == ST_DONE),
        .ld      (accept),
        .step    (ph_step),
        .f_start (bus.f_start),
        .f_step  (step_r),
        .phi     (bus.phi_inc_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            step_r          <= '0;
            n_r             <= '0;
            dwell_r         <= '0;
            cnt             <= '0;
            bus.nco_clken_o <= 1'b0;
            bus.busy        <= 1'b0;
            bus.step_strobe <= 1'b0;
            bus.step_idx    <= '0;
            bus.done        <= 1'b0;
        end else begin
            bus.step_strobe <= 1'b0;
            bus.done        <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    state           <= ST_WARM;
                    step_r          <= bus.f_step;
                    n_r             <= bus.n_steps;
                    dwell_r         <= bus.dwell == '0 ? '0 : bus.dwell - DW'(1);
                    bus.nco_clken_o <= 1'b1;
                    bus.busy        <= 1'b1;
                    bus.step_idx    <= '0;
                end
                ST_WARM: if (bus.abort) begin
                    state           <= ST_IDLE;
                    bus.nco_clken_o <= 1'b0;
                    bus.busy        <= 1'b0;
                end else if (bus.nco_valid && n_r == '0) begin
                    state           <= ST_DONE;
                    bus.nco_clken_o <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                end else if (bus.nco_valid) begin
                    state           <= ST_SWEEP;
                    cnt             <= dwell_r;
                    bus.step_idx    <= '0;
                    bus.step_strobe <= 1'b1;
                end
                ST_SWEEP: if (bus.abort) begin
                    state           <= ST_IDLE;
                    bus.nco_clken_o <= 1'b0;
                    bus.busy        <= 1'b0;
                end else if (cnt != '0) begin
                    cnt <= cnt - DW'(1);
                end else if (last_step) begin
                    state           <= ST_DONE;
                    bus.nco_clken_o <= 1'b0;
                    bus.busy        <= 1'b0;
                    bus.done        <= 1'b1;
                end else begin
                    cnt             <= dwell_r;
                    bus.step_idx    <= bus.step_idx + NSW'(1);
                    bus.step_strobe <= 1'b1;
                end
                ST_DONE: begin
                    state        <= ST_IDLE;
                    bus.step_idx <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed sweeps checked every cycle against a timeline model of the sweep
module tb_nco_sweep_ctrl;
    import nco_sweep_pkg::*;

    localparam int BIG = 1 << 28;

    typedef struct packed {
        logic [31:0] phi;
        logic [15:0] idx;
        logic        clken;
        logic        busy;
        logic        strobe;
        logic        done;
        logic        idx_ok;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmp_on = 1'b0;
    int   edge_n = 0;
    int   n_chk = 0;
    int   n_err = 0;

    int          m_s = BIG, m_v = BIG, m_a = BIG, m_n = 0, m_d = 1;
    logic [31:0] m_fs = '0, m_fst = '0, m_phi0 = '0;
    logic [15:0] m_idx0 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    nco_sweep_if bus ();
    nco_sweep_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    // Expected outputs just after edge k: warm-up, then n steps of max(dwell,1) cycles, then one done cycle
    function automatic exp_t base_at(input int k);
        exp_t r;
        int dd, fin, j;
        dd = m_d == 0 ? 1 : m_d;
        fin = m_v + m_n * dd;
        r = '0;
        r.idx_ok = 1'b1;
        if (k < m_s) begin
            r.phi = m_phi0;
            r.idx = m_idx0;
        end else if (k < m_v) begin
            r.phi = m_fs;
            r.clken = 1'b1;
            r.busy = 1'b1;
            r.idx_ok = 1'b0;
        end else if (k < fin) begin
            j = k - m_v;
            r.phi = m_fs + 32'(j / dd) * m_fst;
            r.idx = 16'(j / dd);
            r.strobe = (j % dd) == 0;
            r.clken = 1'b1;
            r.busy = 1'b1;
        end else if (k == fin) begin
            r.phi = m_n == 0 ? m_fs : m_fs + 32'(m_n - 1) * m_fst;
            r.idx = 16'(m_n - 1);
            r.idx_ok = m_n > 0;
            r.done = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t exp_at(input int k);
        exp_t r;
        int fin;
        fin = m_v + m_n * (m_d == 0 ? 1 : m_d);
        if (m_a > m_s && m_a <= fin && k >= m_a) begin
            r = base_at(m_a - 1);
            r.clken = 1'b0;
            r.busy = 1'b0;
            r.strobe = 1'b0;
            r.done = 1'b0;
        end else begin
            r = base_at(k);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && cmp_on) begin
            e = exp_at(edge_n);
            chk("phi_inc_o", 64'(bus.phi_inc_o), 64'(e.phi));
            chk("nco_clken_o", 64'(bus.nco_clken_o), 64'(e.clken));
            chk("busy", 64'(bus.busy), 64'(e.busy));
            chk("step_strobe", 64'(bus.step_strobe), 64'(e.strobe));
            chk("done", 64'(bus.done), 64'(e.done));
            if (e.idx_ok) chk("step_idx", 64'(bus.step_idx), 64'(e.idx));
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_phi"}, 64'(bus.phi_inc_o), 64'h0);
        chk({nm, "_clken"}, 64'(bus.nco_clken_o), 64'h0);
        chk({nm, "_busy"}, 64'(bus.busy), 64'h0);
        chk({nm, "_strobe"}, 64'(bus.step_strobe), 64'h0);
        chk({nm, "_idx"}, 64'(bus.step_idx), 64'h0);
        chk({nm, "_done"}, 64'(bus.done), 64'h0);
    endtask

    // vdel: edges from start to the one sampling nco_valid high; adel/smid/rrel: edge offsets from start (<=0 unused)
    task automatic sweep(input logic [31:0] fs, input logic [31:0] fst, input int n, input int d,
                         input int vdel, input int adel, input int smid, input int rrel, input bit drop);
        exp_t e;
        int fin;
        tick();
        e = exp_at(edge_n);
        m_phi0 = e.phi;
        m_idx0 = e.idx;
        m_s = edge_n + 1;
        m_v = m_s + vdel;
        m_a = adel > 0 ? m_s + adel : BIG;
        m_n = n;
        m_d = d;
        m_fs = fs;
        m_fst = fst;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.f_start = fs;
        bus.f_step = fst;
        bus.n_steps = 16'(n);
        bus.dwell = 16'(d);
        bus.nco_valid = vdel == 1;
        fin = m_v + n * (d == 0 ? 1 : d);
        while (edge_n + 1 <= fin + 2) begin
            tick();
            bus.start = smid > 0 && edge_n + 1 == m_s + smid;
            bus.f_start = $urandom;
            bus.f_step = $urandom;
            bus.n_steps = 16'($urandom);
            bus.dwell = 16'($urandom);
            if (edge_n + 1 == m_v) bus.nco_valid = 1'b1;
            if (drop && edge_n + 1 > m_v + 1) bus.nco_valid = 1'($urandom_range(0, 1));
            bus.abort = edge_n + 1 == m_a;
            if (rrel > 0 && edge_n + 1 == m_s + rrel) begin
                bus.start = 1'b0;
                bus.abort = 1'b0;
                bus.nco_valid = 1'b0;
                #2 reset = 1'b1;
                #1 chk_zero("async_reset");
                m_s = BIG;
                m_v = BIG;
                m_a = BIG;
                m_n = 0;
                m_phi0 = '0;
                m_idx0 = '0;
                tick();
                reset = 1'b0;
                return;
            end
        end
        bus.nco_valid = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.f_start = '0;
        bus.f_step = '0;
        bus.n_steps = '0;
        bus.dwell = '0;
        bus.nco_valid = 1'b0;
        #1 chk_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        cmp_on = 1'b1;

        sweep(32'h0100_0000, 32'h0010_0000, 4, 3, 10, 0, 0, 0, 1'b0);
        e = exp_at(m_s);      chk("pin1_warm_phi", 64'(e.phi), 64'h0100_0000);
        e = exp_at(m_v + 3);  chk("pin1_strobe1", 64'(e.strobe), 64'h1);
        chk("pin1_idx1", 64'(e.idx), 64'h1);
        e = exp_at(m_v + 4);  chk("pin1_nostrobe", 64'(e.strobe), 64'h0);
        e = exp_at(m_v + 9);  chk("pin1_phi3", 64'(e.phi), 64'h0130_0000);
        e = exp_at(m_v + 12); chk("pin1_done", 64'(e.done), 64'h1);
        chk("pin1_done_clken", 64'(e.clken), 64'h0);

        sweep(32'hFFF0_0000, 32'h0020_0000, 2, 1, 3, 0, 0, 0, 1'b0);
        e = exp_at(m_v);      chk("pin2_phi0", 64'(e.phi), 64'hFFF0_0000);
        e = exp_at(m_v + 1);  chk("pin2_wrap", 64'(e.phi), 64'h0010_0000);
        e = exp_at(m_v + 2);  chk("pin2_done", 64'(e.done), 64'h1);

        sweep(32'h0200_0000, 32'h0000_1000, 0, 5, 4, 0, 0, 0, 1'b0);
        e = exp_at(m_v);      chk("pin3_n0_done", 64'(e.done), 64'h1);
        chk("pin3_n0_strobe", 64'(e.strobe), 64'h0);

        sweep(32'h0300_0000, 32'h0000_0010, 3, 0, 1, 0, 0, 0, 1'b0);
        e = exp_at(m_v + 1);  chk("pin3_d0_strobe", 64'(e.strobe), 64'h1);
        e = exp_at(m_v + 3);  chk("pin3_d0_done", 64'(e.done), 64'h1);

        sweep(32'h0400_0000, 32'h0000_0100, 3, 2, 2, 0, 0, 0, 1'b1);

        sweep(32'h1000_0000, 32'h0100_0000, 8, 3, 2, 11, 0, 0, 1'b0);
        e = exp_at(m_a);      chk("pin4_abort_idx", 64'(e.idx), 64'h2);
        chk("pin4_abort_phi", 64'(e.phi), 64'h1200_0000);
        chk("pin4_abort_done", 64'(e.done), 64'h0);

        sweep(32'h0040_0000, 32'h0000_0100, 3, 2, 3, 0, 5, 0, 1'b0);

        tick();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.f_start = 32'hAAAA_AAAA;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (4) tick();
        chk("start_abort_busy", 64'(bus.busy), 64'h0);
        chk("start_abort_clken", 64'(bus.nco_clken_o), 64'h0);

        sweep(32'h2000_0000, 32'h0001_0000, 6, 2, 2, 0, 0, 7, 1'b0);
        sweep(32'h2000_0000, 32'h0001_0000, 2, 2, 1, 0, 0, 0, 1'b0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
